pc_branch_ctrl: RTL and testbench
=================================

PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter FLUSH_CYCLES, default 2, legal range 1..7, number of cycles FLUSH stays high after a redirect.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 STALL  input  1  hold fetch PC when high.
REQ-006 BR_VALID  input  1  branch or jump instruction present in the execute stage this cycle.
REQ-007 BR_TYPE  input  1  0 = BEQ, 1 = BNE.
REQ-008 JUMP  input  1  unconditional jump; overrides BR_TYPE and BR_EQ when BR_VALID is high.
REQ-009 BR_EQ  input  1  equality flag from the branch comparator (1 = operands equal).
REQ-010 BR_PC  input  32  PC of the executing branch instruction.
REQ-011 BR_IMM  input  32  sign-extended byte offset.
REQ-012 PC  output  32  current fetch PC, registered.
REQ-013 FLUSH  output  1  squash younger in-flight instructions, registered.
REQ-014 TAKEN  output  1  one-cycle pulse marking that a redirect was accepted, registered.
REQ-015 BR_CNT  output  16  count of accepted redirects, registered.

Function
REQ-016 take = BR_VALID & state==RUN & (JUMP | (BR_TYPE==0 & BR_EQ) | (BR_TYPE==1 & ~BR_EQ)).
REQ-017 target = (BR_PC + BR_IMM) mod 2^32, with bits [1:0] forced to 0.
REQ-018 FSM has two states: RUN and FLSH; reset state is RUN.
REQ-019 In RUN with take: PC <= target next edge, regardless of STALL (redirect priority over stall).
REQ-020 In RUN with take: state <= FLSH, flush counter <= FLUSH_CYCLES, FLUSH <= 1, TAKEN <= 1, BR_CNT <= BR_CNT+1.
REQ-021 In RUN without take: PC holds if STALL, else PC <= PC+4 (mod 2^32, wraps 32'hFFFFFFFC -> 0).
REQ-022 In FLSH: BR_VALID is ignored (instruction is squashed); no redirect, no count.
REQ-023 In FLSH: PC holds if STALL, else PC+4; counter decrements every cycle independent of STALL.
REQ-024 In FLSH with counter==1 at the edge: state <= RUN, FLUSH <= 0; FLUSH is high for exactly FLUSH_CYCLES cycles.
REQ-025 TAKEN is high for exactly one cycle per accepted redirect, aligned with the first FLUSH cycle.
REQ-026 BR_CNT wraps 16'hFFFF -> 16'h0000 with no saturation or flag.
REQ-027 Non-taken branches (BR_VALID high, take low) leave FLUSH, TAKEN, BR_CNT unchanged and PC follows REQ-021.
REQ-028 Latency: condition sampled at edge N -> PC = target and FLUSH = 1 visible after edge N.

Reset
REQ-029 RST_N low asynchronously forces PC = RESET_PC, FLUSH = 0, TAKEN = 0, BR_CNT = 0, state = RUN, counter = 0.
REQ-030 Reset asserted mid-flush aborts the flush immediately; first edge after RST_N rises behaves as RUN (PC+4 or hold).
REQ-031 Inputs are don't-care while RST_N is low.

Verification
REQ-032 Reset then 3 cycles with STALL=0, BR_VALID=0 -> PC 0x0, 0x4, 0x8, 0xC; FLUSH=0, BR_CNT=0.
REQ-033 BEQ: BR_VALID=1, BR_TYPE=0, BR_EQ=1, BR_PC=0x100, BR_IMM=0xFFFFFFF0 -> PC=0xF0, TAKEN pulse 1 cycle, FLUSH high 2 cycles, BR_CNT=1.
REQ-034 BNE with BR_EQ=1 (not taken), BR_PC=0x20, BR_IMM=0x40 -> PC continues +4, FLUSH=0, BR_CNT unchanged.
REQ-035 JUMP=1, BR_EQ=0, BR_TYPE=0, STALL=1, BR_PC=0x8, BR_IMM=0x203 -> PC=0x208 (bits[1:0] cleared, stall overridden); second BR_VALID during FLUSH ignored.
REQ-036 PC preloaded to 0xFFFFFFFC, no stall -> next PC=0x0; BR_CNT forced to 0xFFFF by 65535 jumps, one more -> BR_CNT=0x0000.
REQ-037 RST_N pulsed low during the first FLUSH cycle -> PC=RESET_PC, FLUSH=0 immediately (before next edge), normal +4 fetch resumes.

Source files
------------

// File: rtl/pc_branch_ctrl.sv
// Fetch-PC generator with BEQ/BNE/JUMP redirect, fixed-length post-redirect
// flush window, one-cycle TAKEN pulse and a wrapping redirect counter.
module pc_branch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        BR_VALID,
  input  logic        BR_TYPE,
  input  logic        JUMP,
  input  logic        BR_EQ,
  input  logic [31:0] BR_PC,
  input  logic [31:0] BR_IMM,
  output logic [31:0] PC,
  output logic        FLUSH,
  output logic        TAKEN,
  output logic [15:0] BR_CNT
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
    $error("pc_branch_ctrl: FLUSH_CYCLES must be in 1..7");
  end

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  typedef enum logic {RUN, FLSH} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        taken_q, taken_d;
  logic [15:0] brcnt_q, brcnt_d;

  logic        cond;
  logic        take;
  logic [31:0] target;
  logic [31:0] seq_pc;

  always_comb begin
    cond   = JUMP | (~BR_TYPE & BR_EQ) | (BR_TYPE & ~BR_EQ);
    take   = BR_VALID & (state_q == RUN) & cond;
    target = (BR_PC + BR_IMM) & ~32'h0000_0003;
    seq_pc = STALL ? pc_q : pc_q + 32'd4;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = seq_pc;
    flush_d = flush_q;
    taken_d = 1'b0;
    brcnt_d = brcnt_q;
    case (state_q)
      RUN: begin
        // A redirect wins over STALL: the target is loaded even when fetch is held.
        if (take) begin
          pc_d    = target;
          state_d = FLSH;
          cnt_d   = FLUSH_LOAD;
          flush_d = 1'b1;
          taken_d = 1'b1;
          brcnt_d = brcnt_q + 16'd1;
        end
      end
      FLSH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RUN;
          flush_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      taken_q <= 1'b0;
      brcnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      taken_q <= taken_d;
      brcnt_q <= brcnt_d;
    end
  end

  assign PC     = pc_q;
  assign FLUSH  = flush_q;
  assign TAKEN  = taken_q;
  assign BR_CNT = brcnt_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed table-driven bench for pc_branch_ctrl plus hand-written sequences
// for counter wrap, reset during flush and a one-cycle flush variant.
module tb_pc_branch_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        STALL, BR_VALID, BR_TYPE, JUMP, BR_EQ;
  logic [31:0] BR_PC, BR_IMM;
  logic [31:0] PC, PC1;
  logic        FLUSH, TAKEN, FLUSH1, TAKEN1;
  logic [15:0] BR_CNT, BR_CNT1;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  pc_branch_ctrl #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .BR_VALID(BR_VALID),
    .BR_TYPE(BR_TYPE), .JUMP(JUMP), .BR_EQ(BR_EQ), .BR_PC(BR_PC),
    .BR_IMM(BR_IMM), .PC(PC), .FLUSH(FLUSH), .TAKEN(TAKEN), .BR_CNT(BR_CNT)
  );

  pc_branch_ctrl #(.RESET_PC(32'h0000_1000), .FLUSH_CYCLES(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .BR_VALID(BR_VALID),
    .BR_TYPE(BR_TYPE), .JUMP(JUMP), .BR_EQ(BR_EQ), .BR_PC(BR_PC),
    .BR_IMM(BR_IMM), .PC(PC1), .FLUSH(FLUSH1), .TAKEN(TAKEN1), .BR_CNT(BR_CNT1)
  );

  typedef struct {
    logic        stall, valid, btype, jump, eq;
    logic [31:0] bpc, bimm;
    logic [31:0] epc;
    logic        eflush, etaken;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic t, input logic j,
                       input logic e, input logic [31:0] p, input logic [31:0] i);
    STALL = s; BR_VALID = v; BR_TYPE = t; JUMP = j; BR_EQ = e; BR_PC = p; BR_IMM = i;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // stall valid type jump eq  br_pc  br_imm  -> pc flush taken cnt
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'h4,        0,0,16'd0});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'h8,        0,0,16'd0});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'hC,        0,0,16'd0});
    vq.push_back('{1,0,0,0,0, 32'h0,        32'h0,        32'hC,        0,0,16'd0});
    vq.push_back('{0,1,0,0,1, 32'h100,      32'hFFFFFFF0, 32'hF0,       1,1,16'd1});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'hF4,       1,0,16'd1});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'hF8,       0,0,16'd1});
    vq.push_back('{0,1,1,0,1, 32'h20,       32'h40,       32'hFC,       0,0,16'd1});
    vq.push_back('{1,1,0,0,0, 32'h0,        32'h0,        32'hFC,       0,0,16'd1});
    vq.push_back('{1,1,0,1,0, 32'h8,        32'h203,      32'h208,      1,1,16'd2});
    vq.push_back('{0,1,0,0,1, 32'h400,      32'h0,        32'h20C,      1,0,16'd2});
    vq.push_back('{1,1,0,0,1, 32'h400,      32'h0,        32'h20C,      0,0,16'd2});
    vq.push_back('{0,1,1,0,0, 32'h300,      32'h10,       32'h310,      1,1,16'd3});
    vq.push_back('{1,0,0,0,0, 32'h0,        32'h0,        32'h310,      1,0,16'd3});
    vq.push_back('{1,0,0,0,0, 32'h0,        32'h0,        32'h310,      0,0,16'd3});
    vq.push_back('{0,1,0,1,0, 32'hFFFFFFFC, 32'h0,        32'hFFFFFFFC, 1,1,16'd4});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'h0,        1,0,16'd4});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'h4,        0,0,16'd4});
    vq.push_back('{0,1,0,1,0, 32'hFFFFFFF0, 32'h4,        32'hFFFFFFF4, 1,1,16'd5});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'hFFFFFFF8, 1,0,16'd5});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'hFFFFFFFC, 0,0,16'd5});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'h0,        0,0,16'd5});
    vq.push_back('{0,1,0,1,0, 32'hFFFFFFF0, 32'h22,       32'h10,       1,1,16'd6});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'h14,       1,0,16'd6});
    vq.push_back('{0,0,0,0,0, 32'h0,        32'h0,        32'h18,       0,0,16'd6});
    vq.push_back('{0,0,0,1,0, 32'h500,      32'h0,        32'h1C,       0,0,16'd6});

    RST_N = 1'b0;
    idle();
    #12;
    chk("rst_pc",    PC,     32'h0);
    chk("rst_flush", FLUSH,  0);
    chk("rst_taken", TAKEN,  0);
    chk("rst_cnt",   BR_CNT, 0);
    chk("rst_pc1",   PC1,    32'h1000);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vq[k]) begin
      drive(vq[k].stall, vq[k].valid, vq[k].btype, vq[k].jump, vq[k].eq, vq[k].bpc, vq[k].bimm);
      step();
      chk($sformatf("v%0d_pc", k),    PC,     vq[k].epc);
      chk($sformatf("v%0d_flush", k), FLUSH,  32'(vq[k].eflush));
      chk($sformatf("v%0d_taken", k), TAKEN,  32'(vq[k].etaken));
      chk($sformatf("v%0d_cnt", k),   BR_CNT, 32'(vq[k].ecnt));
      @(negedge CLK);
    end

    // Counter wrap: preload near the top, then two more redirects.
    force dut.brcnt_q = 16'hFFFE;
    #1;
    release dut.brcnt_q;
    drive(0, 1, 0, 1, 0, 32'h40, 32'h0);
    step();
    chk("wrap_cnt_ffff", BR_CNT, 32'hFFFF);
    chk("wrap_pc",       PC,     32'h40);
    @(negedge CLK); idle(); step();
    @(negedge CLK); step();
    chk("wrap_flush_done", FLUSH, 0);
    @(negedge CLK);
    drive(0, 1, 0, 1, 0, 32'h60, 32'h0);
    step();
    chk("wrap_cnt_0000", BR_CNT, 32'h0);
    chk("wrap_taken",    TAKEN,  1);
    @(negedge CLK); idle(); step();
    @(negedge CLK); step();
    @(negedge CLK);

    // Reset pulse inside the first flush cycle.
    drive(0, 1, 0, 1, 0, 32'h80, 32'h0);
    step();
    chk("rf_pc_pre",    PC,    32'h80);
    chk("rf_flush_pre", FLUSH, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rf_pc_async",    PC,     32'h0);
    chk("rf_flush_async", FLUSH,  0);
    chk("rf_taken_async", TAKEN,  0);
    chk("rf_cnt_async",   BR_CNT, 0);
    chk("rf_pc1_async",   PC1,    32'h1000);
    @(negedge CLK);
    RST_N = 1'b1;
    idle();
    step();
    chk("rf_pc_4",  PC,    32'h4);
    chk("rf_flush", FLUSH, 0);
    chk("rf_pc1",   PC1,   32'h1004);
    @(negedge CLK); step();
    chk("rf_pc_8",  PC,    32'h8);
    @(negedge CLK);

    // One-cycle flush window on the second instance.
    drive(0, 1, 1, 0, 0, 32'h500, 32'h0);
    step();
    chk("f1_pc",     PC1,    32'h500);
    chk("f1_flush",  FLUSH1, 1);
    chk("f1_taken",  TAKEN1, 1);
    chk("f1_cnt",    BR_CNT1, 1);
    @(negedge CLK); idle(); step();
    chk("f1_flush_end", FLUSH1, 0);
    chk("f1_taken_end", TAKEN1, 0);
    chk("f1_pc_next",   PC1,    32'h504);
    chk("f2_flush_mid", FLUSH,  1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
